// File: rtl/minrv32_mem_adapter.sv
// minrv32_mem_adapter
//
// Bridges the minrv32 core's byte-addressed load/store port onto a simple
// word-oriented valid/ready bus. One core request becomes at most one bus
// transfer. The adapter lines store data and byte enables up with the correct
// byte lanes, and right-justifies load data on the way back. Misaligned
// accesses are rejected without touching the bus. A request with no byte
// mask at all is a no-op. A bus transfer that never completes is abandoned
// after TIMEOUT_CYCLES wait cycles. Every outcome ends in a single DONE cycle,
// which releases the stall and reports the result to the core.
//
// Parameters
//   TIMEOUT_CYCLES  bus-wait cycles before a transfer is abandoned (0 = never)
//
// Ports
//   clk, reset                  clock and asynchronous active-high reset
//   core_valid/addr/wdata       core request, store data right-justified
//   core_wstrb/rmask            right-justified store/load byte masks
//   core_rdata/stall/err        right-justified load data, stall, 1-cycle error
//   bus_valid/addr/wdata/wstrb  word-aligned bus request, lane-aligned data
//   bus_ready/rdata/err         bus completion, read word, error response

module minrv32_mem_adapter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_valid,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [3:0]  core_wstrb,
  input  logic [3:0]  core_rmask,
  output logic [31:0] core_rdata,
  output logic        core_stall,
  output logic        core_err,
  output logic        bus_valid,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  // The wait counter is at least 8 bits wide. It grows only when a longer
  // timeout is configured.
  localparam int WAIT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [1:0]        off_q, off_d;
  logic [3:0]        rmask_q, rmask_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [3:0]  size_mask;
  logic        is_noop;
  logic        misaligned;
  logic        timed_out;
  logic [31:0] load_shifted;
  logic [31:0] load_byte_mask;
  logic [31:0] load_data;

  // Request classification. The access size comes from the store mask when
  // the request is a store, and from the load mask otherwise.
  always_comb begin
    size_mask  = (core_wstrb != 4'b0000) ? core_wstrb : core_rmask;
    is_noop    = (core_wstrb == 4'b0000) && (core_rmask == 4'b0000);
    misaligned = ((size_mask == 4'b0011) && core_addr[0]) ||
                 ((size_mask == 4'b1111) && (core_addr[1:0] != 2'b00));
  end

  // The timeout fires on the wait cycle that would bring the counter up to
  // TIMEOUT_CYCLES. That gives exactly TIMEOUT_CYCLES cycles of bus_valid.
  // A ready in that same cycle still completes normally.
  always_comb begin
    timed_out      = TIMEOUT_EN && (wait_q == WAIT_LAST) && !bus_ready;
    load_shifted   = bus_rdata >> {off_q, 3'b000};
    load_byte_mask = {{8{rmask_q[3]}}, {8{rmask_q[2]}},
                      {8{rmask_q[1]}}, {8{rmask_q[0]}}};
    load_data      = load_shifted & load_byte_mask;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (core_valid) begin
          state_d = (is_noop || misaligned) ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (bus_ready || timed_out) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next-state. The request is latched once in IDLE and then held
  // untouched while the bus transfer runs. rdata_q only changes when a load
  // completes on the bus.
  always_comb begin
    addr_d  = addr_q;
    off_d   = off_q;
    rmask_d = rmask_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    wait_d  = wait_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (core_valid) begin
          addr_d  = {core_addr[31:2], 2'b00};
          off_d   = core_addr[1:0];
          rmask_d = core_rmask;
          wdata_d = core_wdata << {core_addr[1:0], 3'b000};
          wstrb_d = core_wstrb << core_addr[1:0];
          wait_d  = '0;
          err_d   = misaligned && !is_noop;
        end
      end
      ST_BUSY: begin
        if (bus_ready) begin
          err_d = bus_err;
          if (rmask_q != 4'b0000) begin
            rdata_d = load_data;
          end
        end else begin
          wait_d = wait_q + WAIT_W'(1);
          if (timed_out) begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      off_q   <= '0;
      rmask_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      addr_q  <= addr_d;
      off_q   <= off_d;
      rmask_q <= rmask_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs. The stall is raised combinationally as soon as a request shows
  // up in IDLE. DONE drops it, so the core sees its result in that cycle.
  always_comb begin
    bus_valid  = (state_q == ST_BUSY);
    core_stall = ((state_q == ST_IDLE) && core_valid) || (state_q == ST_BUSY);
    core_err   = (state_q == ST_DONE) && err_q;
  end

  assign core_rdata = rdata_q;
  assign bus_addr   = addr_q;
  assign bus_wdata  = wdata_q;
  assign bus_wstrb  = wstrb_q;

endmodule

// File: tb/tb_minrv32_mem_adapter.sv
// tb_minrv32_mem_adapter
//
// Drives core requests, some directed and some random. A scripted bus slave
// answers them. Each request's expected outcome is derived from byte/size
// arithmetic and pushed into a queue. A monitor compares the DUT against the
// head of that queue on every cycle: bus fields, stall length, completion
// data and error.

module tb_minrv32_mem_adapter;

  localparam int TO = 4;

  logic        clk;
  logic        reset;
  logic        core_valid;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [3:0]  core_wstrb;
  logic [3:0]  core_rmask;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        core_err;
  logic        bus_valid;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        bus_err;

  minrv32_mem_adapter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .core_valid (core_valid),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_wstrb (core_wstrb),
    .core_rmask (core_rmask),
    .core_rdata (core_rdata),
    .core_stall (core_stall),
    .core_err   (core_err),
    .bus_valid  (bus_valid),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_wstrb  (bus_wstrb),
    .bus_ready  (bus_ready),
    .bus_rdata  (bus_rdata),
    .bus_err    (bus_err)
  );

  typedef struct {
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic [3:0]  bwstrb;
    logic [31:0] rdata;
    logic        err;
    int          stalls;
    int          bus_cycles;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_miss = 0;
  logic [31:0] model_rdata = 32'h0;

  // Plan for the slave: how many wait cycles to insert, and what to answer.
  int          plan_delay = 0;
  logic [31:0] plan_rdata = 32'h0;
  logic        plan_err = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference outcome for one request, worked out from byte counts and
  // offsets rather than from lane logic.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wstrb, input logic [3:0] rmask,
                               input int delay, input logic [31:0] brdata,
                               input logic berr);
    exp_t        e;
    int          nbytes;
    int          off;
    bit          noop;
    bit          mis;
    bit          tmo;
    logic [31:0] lane_mult;
    longint      word;
    noop   = (wstrb == 4'b0000) && (rmask == 4'b0000);
    nbytes = (wstrb != 4'b0000) ? $countones(wstrb) : $countones(rmask);
    if (nbytes == 0) nbytes = 1;
    off    = int'(addr % 4);
    mis    = !noop && ((addr % nbytes) != 0);
    tmo    = !noop && !mis && (delay >= TO);
    lane_mult  = 32'd1 << (8 * off);
    e.baddr    = addr - 32'(off);
    e.bwdata   = wdata * lane_mult;
    e.bwstrb   = 4'((int'(wstrb) * (1 << off)) % 16);
    e.stalls     = (noop || mis) ? 1 : (tmo ? 1 + TO : delay + 2);
    e.bus_cycles = (noop || mis) ? 0 : (tmo ? TO : delay + 1);
    e.err        = mis ? 1'b1 : (noop ? 1'b0 : (tmo ? 1'b1 : berr));
    if (!noop && !mis && !tmo && (rmask != 4'b0000)) begin
      word = longint'(brdata) >> (8 * off);
      model_rdata = 32'(word % (64'd1 << (8 * nbytes)));
    end
    e.rdata = model_rdata;
    exp_q.push_back(e);
    plan_delay = delay;
    plan_rdata = brdata;
    plan_err   = berr;
    core_valid = 1'b1;
    core_addr  = addr;
    core_wdata = wdata;
    core_wstrb = wstrb;
    core_rmask = rmask;
  endtask

  task automatic waitDone();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!core_stall) done = 1'b1;
    end
    if (!done) begin
      n_miss++;
      $display("[TB] FAIL completion_wait: stall never released for addr 0x%08h", core_addr);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $fatal(1, "[TB] stuck request");
    end
  endtask

  // Scripted bus slave. It counts BUSY cycles and raises ready when the
  // count reaches the planned delay. Outside the ready cycle it drives junk
  // read data and junk error bits, which the DUT must ignore.
  initial begin : slave
    bit in_xfer;
    int cnt;
    in_xfer   = 1'b0;
    cnt       = 0;
    bus_ready = 1'b0;
    bus_rdata = 32'h0;
    bus_err   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus_valid) begin
        if (!in_xfer) begin
          in_xfer = 1'b1;
          cnt = 0;
        end else begin
          cnt++;
        end
        if (cnt == plan_delay) begin
          bus_ready = 1'b1;
          bus_rdata = plan_rdata;
          bus_err   = plan_err;
        end else begin
          bus_ready = 1'b0;
          bus_rdata = $urandom;
          bus_err   = 1'($urandom_range(0, 1));
        end
      end else begin
        in_xfer   = 1'b0;
        bus_ready = 1'b0;
        bus_rdata = $urandom;
        bus_err   = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: compares the DUT against the head of the expectation queue.
  initial begin : monitor
    int          stall_cnt;
    int          bus_cnt;
    logic [31:0] last_rdata;
    exp_t        e;
    stall_cnt  = 0;
    bus_cnt    = 0;
    last_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        checkOutput("reset_bus_valid", 32'(bus_valid), 32'h0);
        checkOutput("reset_core_err", 32'(core_err), 32'h0);
        checkOutput("reset_core_rdata", core_rdata, 32'h0);
        checkOutput("reset_core_stall", 32'(core_stall), 32'h0);
        stall_cnt  = 0;
        bus_cnt    = 0;
        last_rdata = 32'h0;
      end else begin
        if (bus_valid) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_bus_valid", 32'(bus_valid), 32'h0);
          end else begin
            checkOutput("bus_addr", bus_addr, exp_q[0].baddr);
            checkOutput("bus_wdata", bus_wdata, exp_q[0].bwdata);
            checkOutput("bus_wstrb", 32'(bus_wstrb), 32'(exp_q[0].bwstrb));
          end
          bus_cnt++;
        end
        if (core_valid && core_stall) begin
          stall_cnt++;
          checkOutput("err_while_stalled", 32'(core_err), 32'h0);
          checkOutput("rdata_hold", core_rdata, last_rdata);
        end else if (core_valid && !core_stall) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_completion", 32'(core_valid), 32'h0);
          end else begin
            e = exp_q.pop_front();
            checkOutput("core_rdata", core_rdata, e.rdata);
            checkOutput("core_err", 32'(core_err), 32'(e.err));
            checkOutput("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
            checkOutput("bus_cycles", 32'(bus_cnt), 32'(e.bus_cycles));
            last_rdata = e.rdata;
          end
          stall_cnt = 0;
          bus_cnt   = 0;
        end else begin
          checkOutput("idle_stall", 32'(core_stall), 32'h0);
          checkOutput("idle_bus_valid", 32'(bus_valid), 32'h0);
          checkOutput("idle_err", 32'(core_err), 32'h0);
          checkOutput("rdata_hold", core_rdata, last_rdata);
        end
      end
    end
  end

  // Backstop in case something wedges outside the bounded waits.
  initial begin : watchdog
    #2000000;
    n_miss++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $fatal(1, "[TB] watchdog");
  end

  initial begin : driver
    reset      = 1'b1;
    core_valid = 1'b0;
    core_addr  = 32'h0;
    core_wdata = 32'h0;
    core_wstrb = 4'b0000;
    core_rmask = 4'b0000;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #1;

    // LB at 0x103, ready on the first BUSY cycle.
    applyStimulus(32'h103, 32'h0, 4'b0000, 4'b0001, 0, 32'hAABBCCDD, 1'b0);
    waitDone();
    @(posedge clk); #1;
    // SH at 0x202 with three ready-low cycles. Ready lands on the timeout cycle.
    applyStimulus(32'h202, 32'h00001234, 4'b0011, 4'b0000, 3, 32'h0, 1'b0);
    waitDone();
    @(posedge clk); #1;
    // Misaligned LW.
    applyStimulus(32'h106, 32'h0, 4'b0000, 4'b1111, 0, 32'h0, 1'b0);
    waitDone();
    @(posedge clk); #1;
    // Bus never answers: timeout.
    applyStimulus(32'h10, 32'h0, 4'b0000, 4'b1111, 20, 32'h0, 1'b0);
    waitDone();
    @(posedge clk); #1;
    // Bus error response.
    applyStimulus(32'h0, 32'h0, 4'b0000, 4'b1111, 0, 32'h12345678, 1'b1);
    waitDone();
    @(posedge clk); #1;
    // No-op request.
    applyStimulus(32'h33, 32'hFFFF_FFFF, 4'b0000, 4'b0000, 0, 32'h0, 1'b0);
    waitDone();
    @(posedge clk); #1;

    // Reset asserted part-way through a BUSY transfer.
    applyStimulus(32'h40, 32'h0, 4'b0000, 4'b1111, 3, 32'h5555AAAA, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    core_valid = 1'b0;
    #1;
    checkOutput("async_reset_bus_valid", 32'(bus_valid), 32'h0);
    checkOutput("async_reset_stall", 32'(core_stall), 32'h0);
    checkOutput("async_reset_rdata", core_rdata, 32'h0);
    exp_q.delete();
    model_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(32'h20, 32'h0, 4'b0000, 4'b1111, 1, 32'hCAFEF00D, 1'b0);
    waitDone();

    // Random traffic. Requests are either back-to-back or separated by gaps.
    for (int n = 0; n < 150; n++) begin
      int          kind;
      int          size;
      logic [3:0]  mask;
      logic [31:0] addr;
      @(posedge clk); #1;
      if ($urandom_range(0, 2) == 0) begin
        core_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
        end
      end
      kind = $urandom_range(0, 9);
      size = 1 << $urandom_range(0, 2);
      mask = 4'((1 << size) - 1);
      addr = $urandom;
      if ($urandom_range(0, 2) != 0) addr = addr & ~(32'(size) - 32'd1);
      if (kind == 0) begin
        applyStimulus(addr, $urandom, 4'b0000, 4'b0000, 0, $urandom, 1'b0);
      end else if (kind <= 5) begin
        applyStimulus(addr, $urandom, 4'b0000, mask, $urandom_range(0, 5), $urandom,
                      1'($urandom_range(0, 7) == 0));
      end else begin
        applyStimulus(addr, $urandom, mask, 4'b0000, $urandom_range(0, 5), $urandom,
                      1'($urandom_range(0, 7) == 0));
      end
      waitDone();
    end

    @(posedge clk); #1;
    core_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
